// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and constants for the audio playback path.
//               AUDIO_W   - native sample width
//               SILENCE   - mid-scale code used when no sample is available
//               player_state_t - playback sequencer states
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int AUDIO_W = 8;

    // Mid-scale: unsigned PCM midpoint, i.e. a 50% PWM duty (no DC step).
    localparam logic [AUDIO_W-1:0] SILENCE = 8'h80;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        FETCH     = 2'd2,
        CAPTURE   = 2'd3
    } player_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_pwm_player_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module      : pwm_dac
// Description : 1-bit PWM DAC. A free-running WIDTH-bit counter is compared
//               against the level; output is high while count < level, so
//               duty = level / 2^WIDTH. Counter and output clear when en = 0.
// Ports       : CLK, RESET (sync, active-high)
//               en      - run enable; low clears counter and output
//               level   - duty level, takes effect immediately
//               pwm_out - registered PWM output
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_dac #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    input  logic [WIDTH-1:0] level,
    output logic             pwm_out
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_pwm;

    always_ff @(posedge CLK) begin
        if (RESET || !en) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + WIDTH'(1);
            r_pwm <= (r_cnt < level);
        end
    end

    assign pwm_out = r_pwm;

endmodule
`default_nettype wire

// File: rtl/audio_pwm_player.sv
`default_nettype none
// ============================================================================
// Module      : audio_pwm_player
// Description : Playback-side consumer of the audio sample FIFO. Generates
//               the sample-rate tick, pops one sample per tick, holds it for
//               the PWM DAC, substitutes silence on underrun (and counts it),
//               and requests a refill when FIFO occupancy is low.
// Ports       : CLK, RESET (sync, active-high), enable (run/stop)
//               fifo_rd_en / fifo_rd_data / fifo_empty / fifo_rd_valid /
//               fifo_fill_level - FIFO read side
//               refill_req     - playing and occupancy below LOW_WATER
//               sample / sample_strobe - held sample and update pulse
//               pwm_out        - speaker PWM output
//               underrun_count - saturating underrun counter
//               playing        - sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm_player
    import audio_pkg::*;
#(
    parameter int WIDTH      = AUDIO_W,
    parameter int SAMPLE_DIV = 1500,
    parameter int FILL_W     = 11,
    parameter int LOW_WATER  = 256
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              fifo_rd_valid,
    input  logic [FILL_W-1:0] fifo_fill_level,
    output logic              refill_req,
    output logic [WIDTH-1:0]  sample,
    output logic              sample_strobe,
    output logic              pwm_out,
    output logic [15:0]       underrun_count,
    output logic              playing
);

    localparam int                  c_div_w     = $clog2(SAMPLE_DIV);
    localparam logic [c_div_w-1:0]  c_div_last  = c_div_w'(SAMPLE_DIV - 1);
    localparam logic [FILL_W:0]     c_low_water = (FILL_W + 1)'(LOW_WATER);
    localparam logic [WIDTH-1:0]    c_silence   = {1'b1, {(WIDTH-1){1'b0}}};

    player_state_t      r_state;
    player_state_t      w_next_state;
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;
    logic               w_load_data;
    logic               w_underrun;
    logic [WIDTH-1:0]   r_sample;
    logic               r_strobe;
    logic               r_refill;
    logic [15:0]        r_underrun_count;

    assign w_tick  = enable && (r_div_cnt == c_div_last);
    assign playing = (r_state != IDLE);

    // Read strobe is combinational so that dropping enable or asserting
    // RESET cancels a pop in the very cycle it would have happened.
    assign fifo_rd_en = (r_state == FETCH) && enable && !RESET;

    always_comb begin
        w_next_state = r_state;
        w_load_data  = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            IDLE:      w_next_state = WAIT_TICK;
            WAIT_TICK: begin
                if (w_tick) begin
                    if (fifo_empty) w_underrun   = 1'b1;
                    else            w_next_state = FETCH;
                end
            end
            FETCH:     w_next_state = CAPTURE;
            CAPTURE: begin
                w_next_state = WAIT_TICK;
                // Missing read data is treated like an empty FIFO.
                if (fifo_rd_valid) w_load_data = 1'b1;
                else               w_underrun  = 1'b1;
            end
            default:   w_next_state = IDLE;
        endcase
        // Stop overrides everything; in-flight read data is dropped.
        if (!enable) begin
            w_next_state = IDLE;
            w_load_data  = 1'b0;
            w_underrun   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state          <= IDLE;
            r_div_cnt        <= '0;
            r_sample         <= c_silence;
            r_strobe         <= 1'b0;
            r_refill         <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_state  <= w_next_state;
            r_refill <= playing && ({1'b0, fifo_fill_level} < c_low_water);
            r_strobe <= w_load_data || w_underrun;

            if (!enable || w_tick) r_div_cnt <= '0;
            else                   r_div_cnt <= r_div_cnt + c_div_w'(1);

            if (!enable)          r_sample <= c_silence;
            else if (w_load_data) r_sample <= fifo_rd_data;
            else if (w_underrun)  r_sample <= c_silence;

            if (w_underrun && (r_underrun_count != 16'hFFFF))
                r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign sample         = r_sample;
    assign sample_strobe  = r_strobe;
    assign refill_req     = r_refill;
    assign underrun_count = r_underrun_count;

    pwm_dac #(
        .WIDTH (WIDTH)
    ) u_pwm_dac (
        .CLK     (CLK),
        .RESET   (RESET),
        .en      (enable),
        .level   (r_sample),
        .pwm_out (pwm_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_pwm_player
// Description : Self-checking bench for audio_pwm_player with a queue-based
//               FIFO model and a sample-period-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_player;

    localparam int W   = 8;
    localparam int DIV = 8;
    localparam int FW  = 5;
    localparam int LW  = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_valid = 1'b0;
    logic [FW-1:0] fifo_fill_level = '0;
    logic          refill_req;
    logic [W-1:0]  sample;
    logic          sample_strobe;
    logic          pwm_out;
    logic [15:0]   underrun_count;
    logic          playing;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];    // FIFO contents seen by the DUT
    logic [7:0] mq[$];   // reference model's view of FIFO contents
    int         pop_count = 0;
    int         rd_count  = 0;
    bit         auto_fill = 1'b0;
    logic [7:0] auto_byte = 8'h00;
    logic [15:0] exp_under = 16'd0;

    audio_pwm_player #(
        .WIDTH      (W),
        .SAMPLE_DIV (DIV),
        .FILL_W     (FW),
        .LOW_WATER  (LW)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .enable          (enable),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_empty      (fifo_empty),
        .fifo_rd_valid   (fifo_rd_valid),
        .fifo_fill_level (fifo_fill_level),
        .refill_req      (refill_req),
        .sample          (sample),
        .sample_strobe   (sample_strobe),
        .pwm_out         (pwm_out),
        .underrun_count  (underrun_count),
        .playing         (playing)
    );

    always #5 CLK = ~CLK;

    // FIFO model: registered read data, valid one cycle after the strobe.
    always @(posedge CLK) begin
        if (RESET) begin
            fifo_rd_valid <= 1'b0;
        end else begin
            fifo_rd_valid <= 1'b0;
            if (fifo_rd_en && q.size() > 0) begin
                fifo_rd_data  <= q.pop_front();
                fifo_rd_valid <= 1'b1;
                pop_count     <= pop_count + 1;
            end
            if (auto_fill && q.size() < 8) q.push_back(auto_byte);
        end
    end

    always @(negedge CLK) begin
        fifo_empty      = (q.size() == 0);
        fifo_fill_level = FW'(q.size());
        if (fifo_rd_en) rd_count = rd_count + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        mq.push_back(b);
    endtask

    task automatic do_reset();
        enable    = 1'b0;
        auto_fill = 1'b0;
        RESET     = 1'b1;
        q.delete();
        mq.delete();
        cyc(2);
        RESET     = 1'b0;
        exp_under = 16'd0;
    endtask

    // Enable must have just been raised from IDLE. Model: at each tick the
    // FIFO either yields its head (strobe 3 cycles later) or is empty
    // (silence, strobe 1 cycle later, one more underrun).
    task automatic run_periods(input int n, input bit rnd_push);
        int         rd0;
        logic [7:0] exp_s;
        logic [7:0] b;
        bit         und;
        rd0 = rd_count;
        cyc(DIV);
        for (int i = 0; i < n; i++) begin
            und = (mq.size() == 0);
            if (und) begin
                exp_s = 8'h80;
                if (exp_under != 16'hFFFF) exp_under = exp_under + 16'd1;
            end else begin
                exp_s = mq.pop_front();
            end
            check("strobe_tick_p1", sample_strobe, und);
            if (und) check("silence_p1", sample, 8'h80);
            cyc(1);
            check("strobe_tick_p2", sample_strobe, 0);
            cyc(1);
            check("strobe_tick_p3", sample_strobe, !und);
            check("sample", sample, exp_s);
            check("underrun_count", underrun_count, exp_under);
            check("rd_en_per_period", rd_count - rd0, und ? 0 : 1);
            rd0 = rd_count;
            if (rnd_push) begin
                repeat ($urandom_range(0, 2)) begin
                    b = 8'($urandom);
                    if (q.size() < 16) push(b);
                end
            end
            cyc(DIV - 2);
        end
    endtask

    task automatic pwm_window(input logic [7:0] lvl);
        int hi;
        auto_byte = lvl;
        cyc(140);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            if (pwm_out) hi++;
        end
        check("pwm_high_cycles", hi, lvl);
    endtask

    initial begin
        int         pops0;
        logic [7:0] b;

        // ---------------- reset state
        cyc(3);
        check("rst_sample", sample, 8'h80);
        check("rst_strobe", sample_strobe, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_refill", refill_req, 0);
        check("rst_underruns", underrun_count, 0);
        check("rst_playing", playing, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        RESET = 1'b0;
        cyc(1);

        // ---------------- directed playback, then an underrun
        push(8'h10); push(8'h20); push(8'h30);
        enable = 1'b1;
        run_periods(4, 1'b0);
        enable = 1'b0;
        cyc(2);
        check("stop_sample", sample, 8'h80);
        check("stop_playing", playing, 0);

        // ---------------- randomized runs
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat ($urandom_range(0, 6)) begin
                b = 8'($urandom);
                push(b);
            end
            enable = 1'b1;
            run_periods(6, 1'b1);
            enable = 1'b0;
            cyc(2);
        end

        // ---------------- PWM duty: any 256-cycle window is high 'level' times
        do_reset();
        auto_byte = 8'h40;
        auto_fill = 1'b1;
        enable    = 1'b1;
        pwm_window(8'h40);
        pwm_window(8'h00);
        pwm_window(8'hFF);
        check("pwm_no_underrun", underrun_count, 0);
        enable = 1'b0;
        cyc(1);
        check("pwm_off", pwm_out, 0);

        // ---------------- refill request
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(i + 1));
        enable = 1'b1;
        cyc(2 * DIV + 1);
        check("refill_at_fill4", refill_req, 0);
        cyc(1);
        check("refill_at_fill3", refill_req, 1);
        enable = 1'b0;
        cyc(2);
        check("refill_stopped", refill_req, 0);

        // ---------------- stop during FETCH
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        enable = 1'b1;
        cyc(2 * DIV);
        check("fetch_sample_before", sample, 8'h11);
        check("fetch_rd_en", fifo_rd_en, 1);
        pops0  = pop_count;
        enable = 1'b0;
        #1;
        check("fetch_stop_rd_en", fifo_rd_en, 0);
        cyc(1);
        check("fetch_stop_playing", playing, 0);
        check("fetch_stop_sample", sample, 8'h80);
        check("fetch_stop_strobe", sample_strobe, 0);
        check("fetch_stop_pwm", pwm_out, 0);
        cyc(2);
        check("fetch_stop_no_pop", pop_count, pops0);

        // ---------------- RESET during FETCH
        do_reset();
        push(8'h55); push(8'h66);
        enable = 1'b1;
        cyc(DIV);
        check("rst_fetch_rd_en_before", fifo_rd_en, 1);
        RESET = 1'b1;
        #1;
        check("rst_fetch_rd_en", fifo_rd_en, 0);
        cyc(1);
        check("rst_fetch_playing", playing, 0);
        check("rst_fetch_sample", sample, 8'h80);
        RESET  = 1'b0;
        enable = 1'b0;
        cyc(1);

        // ---------------- underrun counter saturation
        do_reset();
        force dut.r_underrun_count = 16'hFFFE;
        #1;
        release dut.r_underrun_count;
        cyc(1);
        check("sat_preload", underrun_count, 16'hFFFE);
        exp_under = 16'hFFFE;
        enable = 1'b1;
        run_periods(2, 1'b0);
        enable = 1'b0;
        cyc(2);
        check("sat_hold_after_stop", underrun_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_pwm_player.md
Name: audio_pwm_player

Overview:
Playback-side consumer of the audio sample FIFO. Generates the sample-rate tick, pops one sample per tick through the FIFO read interface, and converts the held sample to a 1-bit PWM output for the speaker pin. Handles underrun by substituting silence and counting the event. Raises a refill request to the upstream loader when FIFO occupancy drops below a watermark.

Parameters:
WIDTH, 8, sample width in bits; also the PWM counter width.
SAMPLE_DIV, 1500, CLK cycles per sample period (12 MHz / 8 kHz); must be >= 4.
FILL_W, 11, width of fifo_fill_level, i.e. $clog2(DEPTH)+1.
LOW_WATER, 256, refill_req asserts while fill level is below this value.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
enable  in  1  playback run/stop
fifo_rd_en  out  1  FIFO read strobe, combinational from state
fifo_rd_data  in  WIDTH  FIFO read data, registered in the FIFO
fifo_empty  in  1  FIFO empty flag
fifo_rd_valid  in  1  FIFO read-data-valid, one cycle after fifo_rd_en
fifo_fill_level  in  FILL_W  FIFO occupancy
refill_req  out  1  registered; playing and occupancy < LOW_WATER
sample  out  WIDTH  currently held sample
sample_strobe  out  1  one-cycle pulse when sample is updated (real or silence)
pwm_out  out  1  PWM DAC output
underrun_count  out  16  saturating underrun counter
playing  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; sample = SILENCE (2^(WIDTH-1), 8'h80); sample_strobe 0; pwm_out 0; refill_req 0; underrun_count 0; divider and PWM counter 0.
- Divider: counts 0..SAMPLE_DIV-1 while enable = 1, wraps to 0. tick = 1 on the cycle the count equals SAMPLE_DIV-1. Held at 0 while enable = 0.
- FSM states: IDLE, WAIT_TICK, FETCH, CAPTURE.
  - IDLE: when enable = 1, go to WAIT_TICK next cycle.
  - WAIT_TICK with tick and !fifo_empty: go to FETCH.
  - WAIT_TICK with tick and fifo_empty (underrun):
    - sample <= SILENCE, sample_strobe = 1 next cycle.
    - underrun_count++ (saturates at 16'hFFFF).
    - Stay in WAIT_TICK.
  - FETCH: fifo_rd_en = 1 for exactly this cycle; go to CAPTURE.
  - CAPTURE with fifo_rd_valid: sample <= fifo_rd_data, sample_strobe = 1 next cycle, go to WAIT_TICK.
  - CAPTURE without fifo_rd_valid: handle as underrun (silence, count++), go to WAIT_TICK.
- Latency: tick at cycle T -> fifo_rd_en at T+1 -> rd_valid at T+2 -> new sample and strobe visible at T+3. Exactly one pop per sample period. SAMPLE_DIV >= 4 guarantees the FSM is back in WAIT_TICK before the next tick.
- enable = 0 in any state:
  - Next state IDLE.
  - fifo_rd_en gated to 0 in the same cycle.
  - In-flight rd_valid data in CAPTURE is discarded.
  - sample <= SILENCE with no strobe.
  - Divider and PWM counter cleared; pwm_out forced 0.
- PWM:
  - WIDTH-bit counter free-runs while enable; period 2^WIDTH clocks.
  - pwm_out registered = (pwm_cnt < sample): 0 gives always low, 8'hFF gives 255/256 duty, 8'h80 gives 50%.
  - sample changes take effect immediately; no period alignment.
- refill_req: registered (playing && fifo_fill_level < LOW_WATER); compare is unsigned, full FILL_W width.
- underrun_count is cleared only by RESET, not by enable.
- RESET mid-operation: all state returns to reset values on the next edge, and fifo_rd_en drops in that cycle.

Decomposition:
- audio_pkg:
  - AUDIO_W
  - SILENCE constant
  - player_state_t enum {IDLE, WAIT_TICK, FETCH, CAPTURE}
- Sub-module pwm_dac (WIDTH): CLK, RESET, en, level, pwm_out; counter plus compare.
- Parent keeps the divider, FSM, underrun counter and refill logic.

Test Plan (SAMPLE_DIV=8, LOW_WATER=4, FIFO model DEPTH=16):
- Reset, then enable with FIFO preloaded 8'h10, 8'h20, 8'h30 -> one fifo_rd_en per 8 cycles; sample updates 10, 20, 30, each strobe 3 cycles after tick; underrun_count = 0.
- FIFO empty at tick -> sample = 8'h80, strobe pulse, underrun_count 0 -> 1, no fifo_rd_en.
- sample held 8'h40, 256-cycle window -> pwm_out high exactly 64 cycles. 8'h00 -> 0 cycles. 8'hFF -> 255 cycles.
- Fill level 5 -> 3 while playing -> refill_req rises one cycle after fill reaches 3. enable = 0 -> refill_req = 0.
- Deassert enable in the FETCH cycle -> fifo_rd_en = 0 that cycle, state IDLE, sample = 8'h80, pwm_out = 0, FIFO pointer unchanged.
- Force underrun_count to 16'hFFFF via repeated empty ticks -> the next underrun keeps it at 16'hFFFF.
